// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the intersection controller and its lamp/sensor side.
// The master drives the run enable and the requests. The slave (the scheduler) drives the lamps, phase and timer.
interface traffic_phase_scheduler_if #(
   parameter int CW = 12
);
   logic          start;
   logic          c;
   logic          ped_req;
   logic          HG;
   logic          HY;
   logic          HR;
   logic          FG;
   logic          FY;
   logic          FR;
   logic          walk;
   logic [2:0]    phase;
   logic [CW-1:0] timer;

   modport master (
      output start, c, ped_req,
      input  HG, HY, HR, FG, FY, FR, walk, phase, timer
   );

   modport slave (
      input  start, c, ped_req,
      output HG, HY, HR, FG, FY, FR, walk, phase, timer
   );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Highway/farm-road phase scheduler: one FSM with one shared down-counter for all phase durations.
// Optional pedestrian phase (ped_pend flag + PWALK) is compiled in with `define TRAFFIC_PED_REQ_EN.
module traffic_phase_scheduler #(
   parameter int CW    = 12,
   parameter int LONG  = 10,
   parameter int SHORT = 5,
   parameter int WALK  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   traffic_phase_scheduler_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HGRN  = 3'd1,
      HYEL  = 3'd2,
      FGRN  = 3'd3,
      FYEL  = 3'd4,
      PWALK = 3'd5
   } state_t;

   localparam logic [CW-1:0] LONG_LD  = CW'(LONG - 1);
   localparam logic [CW-1:0] SHORT_LD = CW'(SHORT - 1);
   localparam logic [CW-1:0] WALK_LD  = CW'(WALK - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] timer_q, timer_d;
   logic          expired;
   logic          ped_pend;

   assign expired = (timer_q == '0);

`ifdef TRAFFIC_PED_REQ_EN
   logic ped_pend_q, ped_pend_d;

   // Clearing on PWALK entry wins over a request on the same edge: that request is served.
   always_comb begin
      ped_pend_d = ped_pend_q;
      if (!bus.start || (state_d == PWALK && state_q != PWALK))
         ped_pend_d = 1'b0;
      else if (bus.ped_req)
         ped_pend_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ped_pend_q <= 1'b0;
      else        ped_pend_q <= ped_pend_d;
   end

   assign ped_pend = ped_pend_q;
`else
   logic unused_ped_req;
   assign unused_ped_req = bus.ped_req;
   assign ped_pend       = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      if (!bus.start) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:  state_d = HGRN;
            HGRN:  if (expired && (bus.c || ped_pend)) state_d = HYEL;
            HYEL:  if (expired) state_d = ped_pend ? PWALK : (bus.c ? FGRN : HGRN);
            FGRN:  if (expired || !bus.c || ped_pend) state_d = FYEL;
            FYEL:  if (expired) state_d = ped_pend ? PWALK : HGRN;
            PWALK: if (expired) state_d = bus.c ? FGRN : HGRN;
            default: state_d = IDLE;
         endcase
      end
   end

   // Every phase change reloads the shared counter; otherwise it counts down and parks at zero.
   always_comb begin
      timer_d = timer_q;
      if (!bus.start) begin
         timer_d = '0;
      end else if (state_d != state_q) begin
         case (state_d)
            HGRN, FGRN: timer_d = LONG_LD;
            HYEL, FYEL: timer_d = SHORT_LD;
            PWALK:      timer_d = WALK_LD;
            default:    timer_d = '0;
         endcase
      end else if (!expired) begin
         timer_d = timer_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      bus.HG = 1'b0;
      bus.HY = 1'b0;
      bus.HR = 1'b0;
      bus.FG = 1'b0;
      bus.FY = 1'b0;
      bus.FR = 1'b0;
      case (state_q)
         HGRN:    begin bus.HG = 1'b1; bus.FR = 1'b1; end
         HYEL:    begin bus.HY = 1'b1; bus.FR = 1'b1; end
         FGRN:    begin bus.HR = 1'b1; bus.FG = 1'b1; end
         FYEL:    begin bus.HR = 1'b1; bus.FY = 1'b1; end
         default: begin bus.HR = 1'b1; bus.FR = 1'b1; end
      endcase
   end

`ifdef TRAFFIC_PED_REQ_EN
   assign bus.walk = (state_q == PWALK);
`else
   assign bus.walk = 1'b0;
`endif

   assign bus.phase = state_q;
   assign bus.timer = timer_q;

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Phase scheduler for the highway/farm-road intersection. It sequences the six lamp outputs through timed phases from one internal down-counter with programmable long and short durations. It arbitrates the road between the highway (default owner), farm-road car requests (`c`) and, when compiled in, pedestrian requests. It sits directly above the lamp drivers and replaces the separate FSM/counter/mode pieces with a single controller.

## Interface
- `CW`, 12: timer width in bits.
- `LONG`, 10: green duration in cycles. Must satisfy 1..2^CW-1.
- `SHORT`, 5: yellow duration in cycles. Must satisfy 1..2^CW-1.
- `WALK`, 8: pedestrian phase duration in cycles. Used only with `TRAFFIC_PED_REQ_EN`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  run enable. Low forces the IDLE phase.
- `c`  in  1  farm-road car sensor, level.
- `ped_req`  in  1  pedestrian button, any-length pulse.
- `HG`, `HY`, `HR`  out  1 each  highway green, yellow, red.
- `FG`, `FY`, `FR`  out  1 each  farm-road green, yellow, red.
- `walk`  out  1  pedestrian walk lamp.
- `phase`  out  3  current state encoding.
- `timer`  out  CW  current down-counter value.

## Operation
- States and `phase` encodings: IDLE=0, HGRN=1, HYEL=2, FGRN=3, FYEL=4, PWALK=5.
- Lamp outputs are a Moore decode of the state register:
  - IDLE, PWALK: `HR`=`FR`=1.
  - HGRN: `HG`=`FR`=1.
  - HYEL: `HY`=`FR`=1.
  - FGRN: `HR`=`FG`=1.
  - FYEL: `HR`=`FY`=1.
  - `walk`=1 only in PWALK. Exactly one lamp per road is lit in every state.
- Timer:
  - On each state entry it loads duration-1: LONG-1 for HGRN/FGRN, SHORT-1 for HYEL/FYEL, WALK-1 for PWALK.
  - Otherwise it decrements when nonzero and holds at 0.
  - `expired` = (`timer`==0).
- Transitions, evaluated each rising edge. `start`=0 overrides all of them.
  - IDLE → HGRN when `start`=1.
  - HGRN → HYEL when `expired` and (`c` or `ped_pend`). Otherwise stay; the highway keeps green indefinitely.
  - HYEL → PWALK when `expired` and `ped_pend`. Else → FGRN when `expired` and `c`. Else → HGRN when `expired`; the request was withdrawn.
  - FGRN → FYEL when `expired`, or when `c`=0, or when `ped_pend`=1.
  - FYEL → PWALK when `expired` and `ped_pend`. Else → HGRN when `expired`.
  - PWALK → FGRN when `expired` and `c`. Else → HGRN when `expired`.
- `ped_pend` is an internal flag:
  - Set on any cycle with `ped_req`=1.
  - Cleared on the edge that enters PWALK. If a request arrives on that same edge, clear wins; that request is considered served.
- `start` low: IDLE on the next edge, `timer`←0, `ped_pend`←0. Returning high restarts at HGRN with a full LONG.

## Timing
- Reset (async assert): state IDLE, `timer`=0, `ped_pend`=0. Outputs `HR`=`FR`=1, all others 0, `phase`=0. Reset takes effect immediately, including mid-phase.
- Single-cycle latency from input to state change. Outputs follow the state on the same edge with no additional register stage.
- State durations:
  - HGRN lasts ≥ LONG cycles.
  - HYEL and FYEL last exactly SHORT cycles.
  - PWALK lasts exactly WALK cycles.
  - FGRN lasts 1..LONG cycles.
- `c` dropping and `expired` on the same FGRN cycle give a single transition to FYEL.

## Configuration
- `TRAFFIC_PED_REQ_EN` defined: `ped_pend` logic and the PWALK state are present, as described above.
- `TRAFFIC_PED_REQ_EN` undefined:
  - `ped_req` is ignored and `ped_pend` is constant 0.
  - PWALK is unreachable and `walk` is tied 0.
  - All transitions use `c` only.

## Test plan
Defaults throughout: LONG=10, SHORT=5, WALK=8.
- Reset and start: assert `reset`=0 → `phase`=0, `HR`=`FR`=1 without a clock. Release, `start`=1 → `phase`=1 and `timer`=9 after the next edge.
- Full cycle: hold `c`=1 → HGRN 10 cycles, HYEL 5, FGRN 10, FYEL 5, back to HGRN with `timer`=9.
- Idle highway: keep `c`=0 → stays in HGRN for 100 cycles; `timer` holds 0 from cycle 10 onward.
- Early farm exit: drop `c` on the 3rd FGRN cycle → FYEL on the next edge, then HGRN after 5 cycles.
- Pedestrian, macro on: pulse `ped_req` for 1 cycle in HGRN with `c`=0 → HYEL 5 cycles, then PWALK 8 cycles with `walk`=1 and `HR`=`FR`=1, then HGRN.
- Pedestrian, macro off: same stimulus → stays in HGRN and `walk` stays 0.
- Abort: drop `start` mid-FGRN → IDLE on the next edge with all-red. Assert `reset` mid-HYEL → IDLE immediately.
